// File: rtl/multdiv_unit.sv
// Multi-cycle signed multiply (radix-2 Booth) / divide (non-restoring) unit.
// One bit per cycle; result registered in DONE with a one-cycle ready pulse.
module multdiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [5:0]              r_cnt;
    logic signed [WIDTH:0]   r_acc;
    logic signed [WIDTH:0]   r_mcand;
    logic [WIDTH-1:0]        r_q;
    logic                    r_qm1;
    logic [WIDTH-1:0]        r_div;
    logic                    r_is_mul;
    logic                    r_neg;
    logic                    r_dbz;
    logic                    r_ovf;
    logic [WIDTH-1:0]        r_result;
    logic                    r_exc;
    logic                    r_rdy;

    logic                    w_start;
    logic                    w_last;
    logic signed [WIDTH:0]   w_sum;
    logic [WIDTH:0]          w_rsh;
    logic [WIDTH:0]          w_rnew;
    logic [WIDTH-1:0]        w_result;
    logic                    w_exc;

    function automatic logic [WIDTH-1:0] f_mag(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? ({WIDTH{1'b0}} - v) : v;
    endfunction

    function automatic logic [WIDTH-1:0] f_apply_sign(input logic [WIDTH-1:0] v,
                                                     input logic neg);
        return neg ? ({WIDTH{1'b0}} - v) : v;
    endfunction

    // Signed overflow: the upper half plus the result sign bit must all agree.
    function automatic logic f_mul_ovf(input logic [2*WIDTH-1:0] p);
        return !((&p[2*WIDTH-1:WIDTH-1]) || !(|p[2*WIDTH-1:WIDTH-1]));
    endfunction

    assign w_start = ctrl_MULT | ctrl_DIV;
    assign w_last  = (r_cnt == 6'd31);
    assign busy    = (r_state != S_IDLE);

    assign data_result    = r_result;
    assign data_exception = r_exc;
    assign data_resultRDY = r_rdy;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (ctrl_MULT) begin
            w_next = S_MUL;
        end else if (ctrl_DIV) begin
            w_next = (data_operandB == '0) ? S_DONE : S_DIV;
        end else begin
            case (r_state)
                S_MUL, S_DIV: if (w_last) w_next = S_DONE;
                S_DONE:       w_next = S_IDLE;
                default:      w_next = S_IDLE;
            endcase
        end
    end

    // Accumulator is one bit wider than the operand so that subtracting a
    // most-negative multiplicand stays exact.
    always_comb begin
        case ({r_q[0], r_qm1})
            2'b01:   w_sum = r_acc + r_mcand;
            2'b10:   w_sum = r_acc - r_mcand;
            default: w_sum = r_acc;
        endcase
    end

    assign w_rsh  = {r_acc[WIDTH-1:0], r_q[WIDTH-1]};
    assign w_rnew = r_acc[WIDTH] ? (w_rsh + {1'b0, r_div}) : (w_rsh - {1'b0, r_div});

    always_comb begin
        w_result = r_q;
        w_exc    = 1'b0;
        if (r_is_mul) begin
            w_exc = f_mul_ovf({r_acc[WIDTH-1:0], r_q});
        end else if (r_dbz) begin
            w_result = '0;
            w_exc    = 1'b1;
        end else begin
            w_result = f_apply_sign(r_q, r_neg);
            w_exc    = r_ovf;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_q      <= '0;
            r_qm1    <= 1'b0;
            r_div    <= '0;
            r_is_mul <= 1'b0;
            r_neg    <= 1'b0;
            r_dbz    <= 1'b0;
            r_ovf    <= 1'b0;
        end else if (ctrl_MULT) begin
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= {data_operandA[WIDTH-1], data_operandA};
            r_q      <= data_operandB;
            r_qm1    <= 1'b0;
            r_is_mul <= 1'b1;
        end else if (ctrl_DIV) begin
            r_cnt    <= '0;
            r_acc    <= '0;
            r_q      <= f_mag(data_operandA);
            r_div    <= f_mag(data_operandB);
            r_is_mul <= 1'b0;
            r_neg    <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            r_dbz    <= (data_operandB == '0);
            r_ovf    <= (data_operandA == {1'b1, {(WIDTH-1){1'b0}}}) &&
                        (data_operandB == {WIDTH{1'b1}});
        end else begin
            case (r_state)
                S_MUL: begin
                    r_acc <= {w_sum[WIDTH], w_sum[WIDTH:1]};
                    r_q   <= {w_sum[0], r_q[WIDTH-1:1]};
                    r_qm1 <= r_q[0];
                    r_cnt <= r_cnt + 6'd1;
                end
                S_DIV: begin
                    r_acc <= w_rnew;
                    r_q   <= {r_q[WIDTH-2:0], ~w_rnew[WIDTH]};
                    r_cnt <= r_cnt + 6'd1;
                end
                default: ;
            endcase
        end
    end

    // A start sampled in DONE aborts that result: no update, no pulse.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_result <= '0;
            r_exc    <= 1'b0;
            r_rdy    <= 1'b0;
        end else begin
            r_rdy <= 1'b0;
            if (r_state == S_DONE && !w_start) begin
                r_result <= w_result;
                r_exc    <= w_exc;
                r_rdy    <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_multdiv_unit.sv
// Bench for multdiv_unit: directed table, corner sequences and random ops
// against an arithmetic reference model.
module tb_multdiv_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] opA;
    logic [31:0] opB;
    logic        cm;
    logic        cd;
    logic [31:0] res;
    logic        exc;
    logic        rdy;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    multdiv_unit #(.WIDTH(32)) dut (
        .clock          (clock),
        .reset          (reset),
        .data_operandA  (opA),
        .data_operandB  (opB),
        .ctrl_MULT      (cm),
        .ctrl_DIV       (cd),
        .data_result    (res),
        .data_exception (exc),
        .data_resultRDY (rdy),
        .busy           (busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit          m;
        bit          d;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        bit          e;
        int          lat;
    } vec_t;

    vec_t tbl [14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: full-precision arithmetic, truncating signed division.
    function automatic void model(input bit is_mul, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output bit e, output int lat);
        longint p;
        int     ia;
        int     ib;
        ia = a;
        ib = b;
        lat = 33;
        if (is_mul) begin
            p = longint'(ia) * longint'(ib);
            r = p[31:0];
            e = (p != longint'(int'(p[31:0])));
        end else if (ib == 0) begin
            r = 32'h0;
            e = 1'b1;
            lat = 1;
        end else if (ia == 32'h80000000 && ib == -1) begin
            r = 32'h80000000;
            e = 1'b1;
        end else begin
            r = ia / ib;
            e = 1'b0;
        end
    endfunction

    // Called at posedge+1; the following posedge is the start edge E0.
    task automatic start(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b);
        opA = a;
        opB = b;
        cm  = m;
        cd  = d;
        @(posedge clock);
        #1;
        cm  = 1'b0;
        cd  = 1'b0;
        opA = $urandom;
        opB = $urandom;
    endtask

    // Counts edges after E0 until RDY; busy must stay high and the old result held.
    task automatic wait_done(input logic [31:0] prev, output int lat, output bit ok);
        lat = -1;
        ok  = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            if (busy !== 1'b1 || res !== prev) ok = 1'b0;
            @(posedge clock);
            #1;
            if (rdy === 1'b1) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic run_op(input string name, input bit m, input bit d,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] er, input bit ee, input int elat);
        logic [31:0] prev;
        int          lat;
        bit          ok;
        prev = res;
        start(m, d, a, b);
        wait_done(prev, lat, ok);
        check({name, "_latency"}, lat, elat);
        check({name, "_result"}, res, er);
        check({name, "_exc"}, {31'b0, exc}, {31'b0, ee});
        check({name, "_busy_in_rdy"}, {31'b0, busy}, 32'h0);
        check({name, "_busy_hold"}, {31'b0, ok}, 32'h1);
        @(posedge clock);
        #1;
        check({name, "_rdy_fall"}, {31'b0, rdy}, 32'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, limit 1000000 required");
        $fatal(1);
    end

    initial begin
        logic [31:0] er;
        bit          ee;
        int          el;
        int          lat;
        bit          ok;
        bit          stray;
        logic [31:0] prev;

        tbl[0]  = '{1, 0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 0, 33};
        tbl[1]  = '{1, 0, 32'h00010000, 32'h00010000, 32'h00000000, 1, 33};
        tbl[2]  = '{1, 0, 32'h7FFFFFFF, 32'd2,        32'hFFFFFFFE, 1, 33};
        tbl[3]  = '{1, 0, 32'h80000000, 32'h80000000, 32'h00000000, 1, 33};
        tbl[4]  = '{1, 0, 32'h80000000, 32'd1,        32'h80000000, 0, 33};
        tbl[5]  = '{1, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 0, 33};
        tbl[6]  = '{0, 1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 0, 33};
        tbl[7]  = '{0, 1, 32'd100,      32'hFFFFFFF6, 32'hFFFFFFF6, 0, 33};
        tbl[8]  = '{0, 1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 33};
        tbl[9]  = '{0, 1, 32'd5,        32'd0,        32'h00000000, 1, 1};
        tbl[10] = '{0, 1, 32'd0,        32'd7,        32'h00000000, 0, 33};
        tbl[11] = '{0, 1, 32'h80000000, 32'd2,        32'hC0000000, 0, 33};
        tbl[12] = '{0, 1, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'h00000003, 0, 33};
        tbl[13] = '{0, 1, 32'd3,        32'd7,        32'h00000000, 0, 33};

        reset = 1'b0;
        opA   = '0;
        opB   = '0;
        cm    = 1'b0;
        cd    = 1'b0;
        #1;
        check("reset_result", res, 32'h0);
        check("reset_exc", {31'b0, exc}, 32'h0);
        check("reset_rdy", {31'b0, rdy}, 32'h0);
        check("reset_busy", {31'b0, busy}, 32'h0);
        @(posedge clock);
        #1;
        reset = 1'b1;

        for (int i = 0; i < 14; i++)
            run_op($sformatf("tbl%0d", i), tbl[i].m, tbl[i].d, tbl[i].a, tbl[i].b,
                   tbl[i].r, tbl[i].e, tbl[i].lat);

        // Restart: DIV issued at cycle 10 of a MUL aborts it.
        prev  = res;
        stray = 1'b0;
        start(1, 0, 32'd3, 32'd4);
        for (int c = 1; c < 10; c++) begin
            @(posedge clock);
            #1;
            if (rdy !== 1'b0) stray = 1'b1;
        end
        start(0, 1, 32'd20, 32'd4);
        wait_done(prev, lat, ok);
        check("restart_no_mul_rdy", {31'b0, stray}, 32'h0);
        check("restart_latency", lat, 33);
        check("restart_result", res, 32'd5);
        check("restart_hold", {31'b0, ok}, 32'h1);

        // Both starts high: multiply wins.
        run_op("both_high", 1, 1, 32'd6, 32'd3, 32'd18, 0, 33);

        // New start issued in the RDY cycle.
        prev = res;
        start(0, 1, 32'd9, 32'hFFFFFFFD);
        wait_done(prev, lat, ok);
        check("rdycyc_div_result", res, 32'hFFFFFFFD);
        prev = res;
        start(1, 0, 32'd5, 32'd5);
        wait_done(prev, lat, ok);
        check("rdycyc_mul_latency", lat, 33);
        check("rdycyc_mul_result", res, 32'd25);

        // Async reset mid-divide, between clock edges.
        start(0, 1, 32'd1000, 32'd7);
        for (int c = 1; c < 15; c++) begin
            @(posedge clock);
            #1;
        end
        #2;
        reset = 1'b0;
        #1;
        check("areset_result", res, 32'h0);
        check("areset_exc", {31'b0, exc}, 32'h0);
        check("areset_rdy", {31'b0, rdy}, 32'h0);
        check("areset_busy", {31'b0, busy}, 32'h0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        stray = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clock);
            #1;
            if (rdy !== 1'b0 || busy !== 1'b0) stray = 1'b1;
        end
        check("areset_no_stale", {31'b0, stray}, 32'h0);
        run_op("after_reset", 1, 0, 32'd6, 32'd6, 32'd36, 0, 33);

        // Random operations against the reference model.
        for (int i = 0; i < 40; i++) begin
            bit          m;
            logic [31:0] a;
            logic [31:0] b;
            m = $urandom_range(0, 1) == 1;
            case ($urandom_range(0, 3))
                0: begin a = $urandom; b = $urandom; end
                1: begin a = $urandom_range(0, 200) - 100; b = $urandom_range(0, 40) - 20; end
                2: begin a = $urandom; b = $urandom_range(0, 255) - 128; end
                default: begin a = $urandom; b = 32'h0; end
            endcase
            model(m, a, b, er, ee, el);
            run_op($sformatf("rand%0d", i), m, !m, a, b, er, ee, el);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multdiv_unit.md
# multdiv_unit

Multi-cycle signed 32-bit multiply/divide unit in the execute stage. It runs alongside the single-cycle ALU and consumes the same decoded operands and shift/ALU-op decode. The processor steers `mul`/`div` (ALU opcodes 00110/00111) here instead of the ALU. It stalls issue until `data_resultRDY` pulses, then writes `data_result` to the destination register.

## Interface
- `WIDTH`, 32, operand/result width; only 32 is supported.
- `clock` input 1: master clock, rising edge.
- `reset` input 1: asynchronous, active-low; low forces idle and clears all state.
- `data_operandA` input 32: multiplicand / dividend, two's complement.
- `data_operandB` input 32: multiplier / divisor, two's complement.
- `ctrl_MULT` input 1: start multiply; sampled on the rising edge.
- `ctrl_DIV` input 1: start divide; sampled on the rising edge.
- `data_result` output 32: product low word or quotient; held until the next start.
- `data_exception` output 1: overflow or divide-by-zero flag; valid with the result.
- `data_resultRDY` output 1: one-cycle pulse marking result valid.
- `busy` output 1: high while an operation is in flight.

## Operation
- **States:** IDLE, MUL, DIV, DONE.
- **Start:**
  - On any edge with `ctrl_MULT`=1 or `ctrl_DIV`=1, operands are latched, the 6-bit counter clears to 0, and the unit enters MUL or DIV.
  - If both are high, MUL wins.
  - A start in any state, including mid-operation, aborts the current operation and restarts.
  - An aborted operation produces no RDY pulse.
- **MUL:**
  - Radix-2 Booth recoding, one bit per cycle, 32 iterations.
  - 65-bit product/multiplier register {P[31:0], Q[31:0], q-1}, arithmetic right shift each cycle.
  - Result = low 32 bits of the signed 64-bit product.
  - `data_exception`=1 iff product bits [63:31] are not all equal (signed overflow).
- **DIV:**
  - Non-restoring division on magnitudes, 32 iterations, 33-bit remainder register.
  - Final step applies sign: quotient negated iff sign(A) XOR sign(B).
  - Rounding is toward zero; the remainder is discarded.
  - Divisor 0: skip iteration, go to DONE on the next edge, result 0, exception 1.
  - A = 0x80000000, B = 0xFFFFFFFF: result 0x80000000, exception 1.
- **DONE:**
  - `data_result` and `data_exception` are registered.
  - `data_resultRDY`=1 for exactly one cycle.
  - Returns to IDLE the following edge unless a new start is sampled.
- **Width rules:** counter is 6 bits, terminal count 31; all arithmetic is two's complement; no X propagation from unused operand bits.

## Timing
- **Reset values:**
  - `data_result`=0, `data_exception`=0, `data_resultRDY`=0, `busy`=0, state IDLE.
  - Reset is effective immediately on assertion, mid-operation included.
  - The first start is accepted on the first rising edge after reset deasserts.
- **Latency (start edge = E0):**
  - MUL/DIV iterate on E1..E32; result registers and RDY rises at E33; RDY falls at E34.
  - Total: 33 cycles from start to RDY.
  - Divide-by-zero: RDY rises at E1.
- **`busy`:**
  - High from E0 to E33 (inclusive of the DONE cycle transition).
  - Low in IDLE and during the RDY cycle.
  - The processor may issue a new start in the RDY cycle.
- **Hold:** outputs change only at DONE or reset; a new start does not clear `data_result` until that operation completes.
- **Inputs:** operand inputs are don't-care except on the start edge.
- **Start inputs:** `ctrl_MULT`/`ctrl_DIV` held high for several cycles retrigger every edge; the processor drives them as one-cycle pulses.

## Test plan
- **Multiply, basic:** 7 × −3 via `ctrl_MULT` pulse → RDY exactly 33 cycles later, result 0xFFFFFFEB, exception 0, `busy` high for the preceding cycles.
- **Multiply, overflow:** 0x00010000 × 0x00010000 → result 0x00000000, exception 1. Separately, 0x7FFFFFFF × 2 → result 0xFFFFFFFE, exception 1.
- **Divide, signs:**
  - −7 ÷ 2 → 0xFFFFFFFD, exception 0.
  - 100 ÷ −10 → 0xFFFFFFF6.
  - 0x80000000 ÷ 0xFFFFFFFF → 0x80000000, exception 1.
- **Divide by zero:** 5 ÷ 0 → RDY one cycle after start, result 0, exception 1.
- **Restart and priority:**
  - Start MUL 3 × 4.
  - At cycle 10, pulse `ctrl_DIV` 20 ÷ 4 → no RDY for the multiply; RDY 33 cycles after the DIV start with result 5.
  - Both starts high together → multiply result.
- **Async reset:**
  - Drop `reset` low mid-divide (cycle 15) without a clock edge → all outputs 0 immediately.
  - Release, then start 6 × 6 → result 36 after 33 cycles.
  - No stale RDY appears.
